// File: rtl/sobol_sng_ctrl.sv
// rtl/sobol_sng_ctrl.sv - Sobol-sequence stochastic number generator sequencer
// Drives a Sobol generator sample by sample and emits value > sobol_sample as a bitstream.
module sobol_sng_ctrl #(
  parameter int N_SAMPLES = 64,
  parameter int TIMEOUT   = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] value,
  output logic       sob_req,
  output logic [5:0] sob_count,
  input  logic       sob_valid,
  input  logic [5:0] sob_out,
  output logic       bit_out,
  output logic       bit_valid,
  output logic [6:0] ones_cnt,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [5:0]    LAST   = 6'(N_SAMPLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t        state_q, state_d;
  logic [5:0]    value_q;
  logic [TW-1:0] timer_q;
  logic          accept, sample, tmo, advance;
  logic          hit;

  assign hit     = (value_q > sob_out);
  assign sob_req = (state_q == REQ);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // A sample arriving on the timeout cycle still counts, so sob_valid is tested first.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    sample  = 1'b0;
    tmo     = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (sob_valid) begin
          sample  = 1'b1;
          state_d = GAP;
        end else if (timer_q == T_LAST) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      GAP: begin
        if (!sob_valid) begin
          if (sob_count == LAST) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
            state_d = REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q   <= '0;
      timer_q   <= '0;
      sob_count <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      ones_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      if (state_q == REQ) timer_q <= timer_q + TW'(1);
      if (accept) begin
        value_q   <= value;
        timer_q   <= '0;
        sob_count <= '0;
        ones_cnt  <= '0;
        err       <= 1'b0;
      end
      if (sample) begin
        bit_out   <= hit;
        bit_valid <= 1'b1;
        ones_cnt  <= ones_cnt + 7'(hit);
      end
      if (tmo) begin
        err     <= 1'b1;
        timer_q <= '0;
      end
      if (advance) begin
        sob_count <= sob_count + 6'd1;
        timer_q   <= '0;
      end
    end
  end

endmodule

// File: doc/sobol_sng_ctrl.md
SOBOL_SNG_CTRL -- requirements
Module: sobol_sng_ctrl

Interface
REQ-001 SHALL have parameter: N_SAMPLES, 64, samples per conversion (2..64).
REQ-002 SHALL have parameter: TIMEOUT, 63, max cycles waiting for sob_valid per sample.
REQ-003 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: start  input  1  pulse; begin a conversion when idle.
REQ-006 SHALL have port: value  input  6  binary operand, latched on accepted start.
REQ-007 SHALL have port: sob_req  output  1  request to Sobol generator (drives its en_next).
REQ-008 SHALL have port: sob_count  output  6  sample index to generator (drives its count).
REQ-009 SHALL have port: sob_valid  input  1  generator result ready (its en_out).
REQ-010 SHALL have port: sob_out  input  6  generator result.
REQ-011 SHALL have port: bit_out  output  1  stochastic bit for current sample.
REQ-012 SHALL have port: bit_valid  output  1  one-cycle strobe qualifying bit_out.
REQ-013 SHALL have port: ones_cnt  output  7  count of 1-bits in current/last conversion.
REQ-014 SHALL have port: busy  output  1  high from accepted start until DONE exits.
REQ-015 SHALL have port: done  output  1  one-cycle pulse at conversion end.
REQ-016 SHALL have port: err  output  1  sticky timeout flag, cleared by next accepted start.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, GAP, DONE.
REQ-018 IDLE: start=1 -> latch value, clear ones_cnt, err, sob_count=0, go REQ; start in any other state ignored.
REQ-019 REQ: sob_req=1, sob_count held stable; timer increments each cycle.
REQ-020 REQ with sob_valid=1: capture bit_out=(value_latched > sob_out), unsigned compare; bit_valid=1 next cycle; ones_cnt += bit_out on that same cycle; go GAP.
REQ-021 REQ with timer reaching TIMEOUT and sob_valid=0: set err, drop sob_req, go IDLE, no done pulse.
REQ-022 GAP: sob_req=0; stay until sob_valid=0 observed (min 1 cycle) so generator clears.
REQ-023 GAP exit: if sob_count==N_SAMPLES-1 go DONE, else sob_count+1, timer cleared, go REQ.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; ones_cnt holds final value until next start.
REQ-025 sob_count SHALL never wrap within a conversion; max value N_SAMPLES-1.
REQ-026 busy=1 in REQ, GAP, DONE; 0 in IDLE.
REQ-027 sob_valid seen in GAP or IDLE SHALL be ignored (no bit_valid).
REQ-028 sob_valid and timeout on same REQ cycle: sample wins, no err.
REQ-029 Minimum per-sample period SHALL be 3 cycles (REQ hit, GAP, REQ); value changes after start SHALL NOT affect the conversion.

Reset
REQ-030 rst low SHALL immediately force IDLE, sob_req=0, sob_count=0, bit_out=0, bit_valid=0, ones_cnt=0, busy=0, done=0, err=0, timer=0.
REQ-031 Reset mid-conversion SHALL abort without done pulse; first start after rst release starts fresh from sob_count=0.

Verification
REQ-032 value=0, generator model sob_out=sob_count, 1-cycle latency -> 64 bit_valid strobes all bit_out=0, ones_cnt=0, one done pulse.
REQ-033 value=32, same model -> bits 1 for counts 0..31, 0 for 32..63, ones_cnt=32, done once.
REQ-034 value=63, model latency 5 cycles -> ones_cnt=63; each sob_count held stable across its REQ; sob_req low >=1 cycle between samples.
REQ-035 sob_valid tied 0 after start -> err=1 at TIMEOUT=63 cycles in REQ, busy=0 next, no done; next start clears err.
REQ-036 start pulsed while busy at sample 10, value changed to 5 -> ignored; results match original latched value.
REQ-037 rst asserted at sample 20 -> all outputs zero immediately; new start after release yields full 64-sample run from sob_count=0.
